// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the fetch PC, a direct-mapped one-word-per-line
// instruction cache, and a single decoder slot fed from cache hits or memory fills.
module inst_fetch #(
  parameter int               ADDR_W   = 32,
  parameter int               IC_IDX_W = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              if_mc_req_out,
  output logic [ADDR_W-1:0] if_mc_addr_out,
  input  logic              mc_if_done_in,
  input  logic [ADDR_W-1:0] mc_if_data_in,
  output logic              if_dec_valid_out,
  output logic [ADDR_W-1:0] if_dec_inst_out,
  output logic [ADDR_W-1:0] if_dec_pc_out,
  input  logic              dec_if_ready_in,
  input  logic              bp_if_en_in,
  input  logic [ADDR_W-1:0] bp_if_pc_in,
  input  logic              rob_if_flush_in,
  input  logic [ADDR_W-1:0] rob_if_pc_in
);

  localparam int LINES = 1 << IC_IDX_W;
  localparam int TAG_W = ADDR_W - IC_IDX_W - 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state;
  logic                stale;
  logic [ADDR_W-1:0]   pc;

  logic [LINES-1:0]    ic_valid;
  logic [TAG_W-1:0]    ic_tag  [LINES];
  logic [ADDR_W-1:0]   ic_data [LINES];

  logic [IC_IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [IC_IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;
  logic                transfer;
  logic                slot_free;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_target;
  logic                fill;

  always_comb begin
    pc_idx          = pc[IC_IDX_W+1:2];
    pc_tag          = pc[ADDR_W-1:IC_IDX_W+2];
    fill_idx        = if_mc_addr_out[IC_IDX_W+1:2];
    fill_tag        = if_mc_addr_out[ADDR_W-1:IC_IDX_W+2];
    hit             = ic_valid[pc_idx] && (ic_tag[pc_idx] == pc_tag);
    transfer        = if_dec_valid_out && dec_if_ready_in;
    slot_free       = !if_dec_valid_out || transfer;
    // A predicted-taken redirect only counts when the branch itself is handed over
    redirect        = rob_if_flush_in || (bp_if_en_in && transfer);
    redirect_target = rob_if_flush_in ? rob_if_pc_in : bp_if_pc_in;
    fill            = (state == WAIT) && mc_if_done_in;
  end

  // Tag and data arrays carry no reset; only the valid bits need clearing
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      ic_tag[fill_idx]  <= fill_tag;
      ic_data[fill_idx] <= mc_if_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      stale            <= 1'b0;
      pc               <= RESET_PC & ALIGN_MASK;
      ic_valid         <= '0;
      if_mc_req_out    <= 1'b0;
      if_mc_addr_out   <= '0;
      if_dec_valid_out <= 1'b0;
      if_dec_inst_out  <= '0;
      if_dec_pc_out    <= '0;
    end else if (rdy_in) begin
      if (transfer) begin
        if_dec_valid_out <= 1'b0;
      end
      // A fill always completes, even when its data is no longer wanted
      if (fill) begin
        ic_valid[fill_idx] <= 1'b1;
        if_mc_req_out      <= 1'b0;
        state              <= IDLE;
      end
      if (redirect) begin
        pc               <= redirect_target & ALIGN_MASK;
        if_dec_valid_out <= 1'b0;
        stale            <= (state == WAIT) && !mc_if_done_in;
      end else begin
        case (state)
          IDLE: begin
            if (slot_free) begin
              if (hit) begin
                if_dec_valid_out <= 1'b1;
                if_dec_inst_out  <= ic_data[pc_idx];
                if_dec_pc_out    <= pc;
                pc               <= pc + ADDR_W'(4);
              end else begin
                if_mc_req_out  <= 1'b1;
                if_mc_addr_out <= pc;
                state          <= WAIT;
              end
            end
          end
          WAIT: begin
            if (mc_if_done_in) begin
              if (stale) begin
                stale <= 1'b0;
              end else if (slot_free) begin
                if_dec_valid_out <= 1'b1;
                if_dec_inst_out  <= mc_if_data_in;
                if_dec_pc_out    <= if_mc_addr_out;
                pc               <= if_mc_addr_out + ADDR_W'(4);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the out-of-order RV32I core. Sits between the memory controller and the decoder.
- Holds the architectural fetch PC and keeps a small direct-mapped instruction cache.
- Hands one instruction and its PC per handshake to the decoder.
- Accepts redirects from the branch predictor (predicted-taken target) and from the reorder buffer (mispredict flush).

Parameters:
- ADDR_W, 32, address and instruction width.
- IC_IDX_W, 5, icache index bits; the cache has 2^IC_IDX_W one-word lines.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low (0 = reset).
- rdy_in  in  1  global stall; 0 freezes all state.
- if_mc_req_out  out  1  memory read request, level.
- if_mc_addr_out  out  ADDR_W  word address of the request.
- mc_if_done_in  in  1  one-cycle pulse: read data valid.
- mc_if_data_in  in  ADDR_W  fetched instruction word.
- if_dec_valid_out  out  1  instruction slot valid.
- if_dec_inst_out  out  ADDR_W  instruction word.
- if_dec_pc_out  out  ADDR_W  PC of that instruction.
- dec_if_ready_in  in  1  decoder accepts the slot this cycle.
- bp_if_en_in  in  1  predicted-taken redirect; only meaningful in a cycle where the slot handshake fires.
- bp_if_pc_in  in  ADDR_W  predicted target.
- rob_if_flush_in  in  1  mispredict flush.
- rob_if_pc_in  in  ADDR_W  correct restart PC.

Behaviour:
- Reset (rst_in=0, async):
  - pc=RESET_PC; all icache valid bits=0.
  - Outputs: if_dec_valid_out=0, if_dec_inst_out=0, if_dec_pc_out=0, if_mc_req_out=0, if_mc_addr_out=0.
  - state=IDLE, stale=0.
- rdy_in=0: no register changes. Outputs hold; the memory controller must not pulse done while rdy_in=0.
- Handshake: a transfer occurs when if_dec_valid_out && dec_if_ready_in. The slot is free when it is not valid, or when it transfers this cycle.
- Icache:
  - Index = pc[IC_IDX_W+1:2]; tag = pc[ADDR_W-1:IC_IDX_W+2].
  - Lookup is combinational on pc.
- State machine:
  - IDLE, slot free, hit: slot <= {cached word, pc}; valid=1; pc <= pc+4. One-cycle hit latency.
  - IDLE, slot free, miss: req=1; addr=pc; go to WAIT.
  - IDLE, slot occupied and not transferring: no action.
  - WAIT: req and addr held stable until done.
    - On done: write the line (valid, tag, data) at addr; deassert req; go to IDLE.
    - If stale=0 and the slot is free: load the slot with {data, addr}; pc <= addr+4.
    - If stale=0 and the slot is not free: nothing is loaded; the next IDLE cycle hits.
    - If stale=1: data is not delivered; stale <= 0; the line is still filled.
- Redirect priority is rob flush > bp redirect > normal advance.
- rob_if_flush_in=1, any state:
  - pc <= rob_if_pc_in; slot valid <= 0.
  - If state=WAIT and done is not this cycle: stale <= 1.
  - If done arrives in the same cycle: fill the cache, do not deliver, stale stays 0, go to IDLE.
- bp_if_en_in=1 with a transfer that cycle: same effect as a flush, with target bp_if_pc_in (the slot behind the branch is discarded).
- bp_if_en_in without a transfer is ignored.
- PC arithmetic wraps modulo 2^ADDR_W. pc[1:0] is always forced to 0.
- Outstanding memory requests are never aborted; at most one is outstanding.
- A new request issues no earlier than the cycle after done.

Test Plan:
- Cold start, RESET_PC=0, memory returns 32'h00000013 at addr 0 after 3 cycles, ready=1 -> req addr 0; valid with inst 13, pc 0; next req addr 4.
- Loop refetch: after fetching 0 and 4, flush to 0 -> second fetch of 0 hits; valid the cycle after the flush; no req for addr 0.
- BP redirect: handshake on pc 8 with bp_if_en_in=1, bp_if_pc_in=0x40 -> slot for pc 12 dropped; next delivered pc=0x40.
- Stale fill: flush to 0x100 while a request for 0x20 is outstanding -> 0x20 data not delivered; next req addr 0x100; later a fetch of 0x20 hits.
- Backpressure and stall:
  - dec_if_ready_in=0 for 5 cycles -> slot is stable and pc does not advance.
  - rdy_in=0 mid-WAIT -> req and addr unchanged.
- Async reset mid-WAIT -> outputs 0 immediately, without waiting for a clock edge; after release, the fetch restarts at RESET_PC and every lookup misses.
